// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// state enum, opcode values, ALUOp / ALUSrcB / PCSource selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// In: clock, reset_n, opcode, zero, mem_ready. Out: datapath strobes/selects, illegal_op, state_o.
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   state_t state;
   state_t state_nx;
   logic   is_store;
   logic   is_store_nx;
   logic   illegal_nx;

   logic pc_wr, pc_wr_c, mem_rd, mem_wr, ir_wr, reg_wr;

   // opcode is only valid in DECODE, so remember lw vs sw for MEMADR
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_FETCH;
         is_store   <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state      <= state_nx;
         is_store   <= is_store_nx;
         illegal_op <= illegal_nx;
      end
   end

   always_comb begin
      state_nx    = S_FETCH;
      is_store_nx = is_store;
      illegal_nx  = illegal_op;
      case (state)
         S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            is_store_nx = (opcode == OP_SW);
            unique case (1'b1)
               (opcode == OP_RTYPE):
                  state_nx = S_EXEC;
               (opcode == OP_LW),
               (opcode == OP_SW):
                  state_nx = S_MEMADR;
               (opcode == OP_BEQ):
                  state_nx = S_BRANCH;
               (opcode == OP_ADDI):
                  state_nx = S_ADDIEX;
               (opcode == OP_J):
                  state_nx = S_JUMP;
               default: begin
                  state_nx   = S_FETCH;
                  illegal_nx = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_nx = is_store ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_nx = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_nx = S_FETCH;
         S_MEMWR:  state_nx = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nx = S_RWB;
         S_RWB:    state_nx = S_FETCH;
         S_BRANCH: state_nx = S_FETCH;
         S_ADDIEX: state_nx = S_IWB;
         S_IWB:    state_nx = S_FETCH;
         S_JUMP:   state_nx = S_FETCH;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_comb begin
      pc_wr    = 1'b0;
      pc_wr_c  = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      IorD     = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_B;
      ALUOp    = ALUOP_ADD;
      PCSource = PCSRC_ALU;
      case (state)
         S_FETCH: begin
            mem_rd  = 1'b1;
            ALUSrcB = SRCB_FOUR;
            ir_wr   = mem_ready;
            pc_wr   = mem_ready;
         end
         S_DECODE: ALUSrcB = SRCB_IMMSH2;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            IorD   = 1'b1;
         end
         S_MEMWB: begin
            reg_wr   = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            mem_wr = 1'b1;
            IorD   = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            reg_wr = 1'b1;
            RegDst = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_SUB;
            pc_wr_c  = 1'b1;
            PCSource = PCSRC_ALUOUT;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_IWB:  reg_wr = 1'b1;
         S_JUMP: begin
            pc_wr    = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   // strobes are killed combinationally so an abort never leaks a write
   assign PCWrite     = pc_wr   & reset_n;
   assign PCWriteCond = pc_wr_c & reset_n;
   assign MemRead     = mem_rd  & reset_n;
   assign MemWrite    = mem_wr  & reset_n;
   assign IRWrite     = ir_wr   & reset_n;
   assign RegWrite    = reg_wr  & reset_n;

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table with
// scoreboard queue, plus hand sequences for latency and abort.
module tb_multicycle_control;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state_o;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   multicycle_control dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode),
      .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
   );

   // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RD,RW,ASA,ASB[2],AOP[2],PCS[2]}
   logic [15:0] outs;
   assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource};

   typedef struct {
      logic       rst_n;
      logic [5:0] op;
      logic       z;
      logic       mr;
      logic [3:0] st;
      logic       ill;
   } vec_t;

   typedef struct {
      logic [3:0]  st;
      logic [15:0] o;
      logic        ill;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic logic [15:0] exp_outs(logic [3:0] st, logic mr,
                                            logic rn);
      logic [15:0] v;
      case (st)
         4'd0:  v = mr ? 16'h9410 : 16'h1010;
         4'd1:  v = 16'h0030;
         4'd2:  v = 16'h0060;
         4'd3:  v = 16'h3000;
         4'd4:  v = 16'h0280;
         4'd5:  v = 16'h2800;
         4'd6:  v = 16'h0048;
         4'd7:  v = 16'h0180;
         4'd8:  v = 16'h4045;
         4'd9:  v = 16'h0060;
         4'd10: v = 16'h0080;
         4'd11: v = 16'h8002;
         default: v = 16'hxxxx;
      endcase
      if (!rn) v = v & 16'h237F;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(logic rn, logic [5:0] op, logic z, logic mr,
                      logic [3:0] st, logic ill);
      vec_t v;
      v.rst_n = rn; v.op = op; v.z = z; v.mr = mr;
      v.st = st; v.ill = ill;
      vecs.push_back(v);
   endtask

   initial begin
      exp_t e;
      int   cyc;

      // reset, R-type
      add(0, 6'h00, 0, 1, 0, 0);
      add(0, 6'h00, 0, 1, 0, 0);
      add(1, 6'h2a, 0, 1, 0, 0);
      add(1, 6'h00, 0, 1, 1, 0);
      add(1, 6'h3f, 0, 1, 6, 0);
      add(1, 6'h3f, 0, 1, 7, 0);
      // lw with 2-cycle stall in MEMRD
      add(1, 6'h2a, 0, 1, 0, 0);
      add(1, 6'h23, 0, 1, 1, 0);
      add(1, 6'h2b, 0, 1, 2, 0);
      add(1, 6'h2b, 0, 0, 3, 0);
      add(1, 6'h00, 0, 0, 3, 0);
      add(1, 6'h00, 0, 1, 3, 0);
      add(1, 6'h00, 0, 1, 4, 0);
      // beq zero=1 then zero=0
      add(1, 6'h00, 1, 1, 0, 0);
      add(1, 6'h04, 0, 1, 1, 0);
      add(1, 6'h00, 1, 1, 8, 0);
      add(1, 6'h00, 0, 1, 0, 0);
      add(1, 6'h04, 1, 1, 1, 0);
      add(1, 6'h00, 0, 1, 8, 0);
      // illegal then addi, flag sticks
      add(1, 6'h00, 0, 1, 0, 0);
      add(1, 6'h3f, 0, 1, 1, 0);
      add(1, 6'h00, 0, 1, 0, 1);
      add(1, 6'h08, 0, 1, 1, 1);
      add(1, 6'h3f, 0, 1, 9, 1);
      add(1, 6'h3f, 0, 1, 10, 1);
      // sw aborted by reset in MEMWR
      add(1, 6'h00, 0, 1, 0, 1);
      add(1, 6'h2b, 0, 1, 1, 1);
      add(1, 6'h00, 0, 1, 2, 1);
      add(1, 6'h00, 0, 0, 5, 1);
      add(0, 6'h00, 0, 0, 0, 0);
      // 4-cycle FETCH stall, then j
      add(1, 6'h00, 0, 0, 0, 0);
      add(1, 6'h00, 0, 0, 0, 0);
      add(1, 6'h00, 0, 0, 0, 0);
      add(1, 6'h00, 0, 0, 0, 0);
      add(1, 6'h02, 0, 1, 0, 0);
      add(1, 6'h02, 0, 1, 1, 0);
      add(1, 6'h00, 0, 1, 11, 0);
      add(1, 6'h00, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clock);
         reset_n   = vecs[i].rst_n;
         opcode    = vecs[i].op;
         zero      = vecs[i].z;
         mem_ready = vecs[i].mr;
         e.st  = vecs[i].st;
         e.ill = vecs[i].ill;
         e.o   = exp_outs(vecs[i].st, vecs[i].mr, vecs[i].rst_n);
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d state", i), 32'(state_o), 32'(e.st));
         chk($sformatf("v%0d outs", i), 32'(outs), 32'(e.o));
         chk($sformatf("v%0d illegal", i), 32'(illegal_op), 32'(e.ill));
      end

      // R-type latency with mem_ready high
      @(negedge clock);
      mem_ready = 1'b1;
      opcode    = 6'h00;
      #1;
      chk("lat start", 32'(state_o), 32'd0);
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (state_o != 4'd0 && cyc < 20);
      chk("rtype latency", cyc, 32'd4);

      // lw aborted in MEMWB: no write-back after reset asserts
      opcode = 6'h23;
      cyc = 0;
      while (state_o != 4'd4 && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      chk("reach MEMWB", 32'(state_o), 32'd4);
      #1;
      chk("MEMWB regwrite", 32'(RegWrite), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort regwrite", 32'(RegWrite), 32'd0);
      chk("abort state", 32'(state_o), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      chk("post abort", 32'(state_o), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back across several cycles. It drives every datapath strobe and mux select: PC, instruction register, memory, RegisterFile (`RegWrite`, `RegDst`, `MemtoReg`) and the ALU input/op selects. It waits on a memory ready handshake and flags illegal opcodes.

## Interface
- No parameters. Opcode and ALUOp encodings are fixed in the shared package.
- `clock` in 1 — single clock, all state updates on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; sampled only in DECODE.
- `zero` in 1 — ALU zero flag; used only in BRANCH.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `PCWrite` out 1 — unconditional PC load.
- `PCWriteCond` out 1 — PC load if `zero`.
- `IorD` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead` out 1 — memory read request.
- `MemWrite` out 1 — memory write request.
- `IRWrite` out 1 — instruction register load.
- `MemtoReg` out 1 — write-back data select: 0 = ALUOut, 1 = MDR.
- `RegDst` out 1 — write-back register select: 0 = rt, 1 = rd.
- `RegWrite` out 1 — RegisterFile write enable.
- `ALUSrcA` out 1 — ALU A select: 0 = PC, 1 = A register.
- `ALUSrcB` out 2 — ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `ALUOp` out 2 — 00 = add, 01 = subtract, 10 = funct-decoded.
- `PCSource` out 2 — PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1 — sticky flag; set on an unknown opcode.
- `state_o` out 4 — current state, for debug.

## Operation
- States:
  - FETCH 0
  - DECODE 1
  - MEMADR 2
  - MEMRD 3
  - MEMWB 4
  - MEMWR 5
  - EXEC 6
  - RWB 7
  - BRANCH 8
  - ADDIEX 9
  - IWB 10
  - JUMP 11
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH, and set `illegal_op`.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0 → FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Hold until `mem_ready`, then go to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10 → RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0 → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01 → FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00 → IWB.
- IWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0 → FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10 → FETCH.
- Any output not listed for a state is 0.
- A state encoding outside 0–11 is forced to FETCH on the next clock.
- `illegal_op` is cleared only by reset.

## Timing
- Moore machine. All outputs decode from the registered state, except `IRWrite` and `PCWrite` in FETCH, which also depend on `mem_ready`.
- Reset values:
  - state = FETCH, `illegal_op` = 0.
  - While `reset_n`=0, every strobe output is forced to 0 combinationally: `PCWrite`, `PCWriteCond`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`.
- Reset asserted mid-instruction aborts it immediately. No partial write-back occurs after reset asserts.
- Latency with `mem_ready` always 1:
  - lw: 5 cycles
  - R-type, sw, addi: 4 cycles
  - beq, j: 3 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs stay stable during the stall.
- `RegWrite` is asserted for exactly one cycle per instruction that writes a register.
- `opcode` is ignored outside DECODE.
- `zero` is ignored outside BRANCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp constants and ALUSrcB / PCSource encodings.
- Single module with three parts: state register, next-state logic, output decode.
- No sub-module. The funct-level ALU control stays in the existing separate alu_control block.

## Test plan
- Reset held, then released, `mem_ready`=1, opcode 000000 → states 0,1,6,7,0. `RegWrite`=1 only in cycle 4, with `RegDst`=1.
- opcode 100011, `mem_ready` low for 2 cycles in MEMRD → 0,1,2,3,3,3,4,0. `MemRead` and `IorD` held for 3 cycles; `MemtoReg`=1 in MEMWB.
- opcode 000100, `zero`=1, then a second instruction with `zero`=0 → `PCWriteCond`=1 with `PCSource`=01 in BRANCH both times; 3 cycles each.
- opcode 111111 → DECODE→FETCH, `illegal_op`=1 and stays 1 through a following addi (opcode 001000: 0,1,9,10,0).
- `reset_n` pulsed low during MEMWR with `mem_ready`=0 → `MemWrite` drops to 0 immediately; state_o=0 after reset is released.
- `mem_ready`=0 for 4 cycles in FETCH → `IRWrite` and `PCWrite` stay 0, then pulse for one cycle when `mem_ready` rises; state advances to DECODE.
